// File: rtl/neuron_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : neuron_seq_pkg                                                   |
// | Purpose : Shared types and constants for the neuron tick sequencer:        |
// |           sweep state encoding and reset-mode codes.                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package neuron_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int RESET_HARD   = 0;
  localparam int RESET_LINEAR = 1;

endpackage
`default_nettype wire

// File: rtl/neuron_threshold_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : neuron_threshold_eval                                            |
// | Purpose : Combinational spike / reset evaluation for one neuron.           |
// | Ports   : potential        in  current membrane potential (signed)         |
// |           pos_threshold    in  firing threshold (signed)                   |
// |           neg_threshold    in  lower threshold (signed)                    |
// |           reset_potential  in  value used by hard reset                    |
// |           reset_mode       in  0 = hard, 1 = linear, others reset to 0     |
// |           new_potential    out potential to write back                     |
// |           spike            out neuron fires this tick                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module neuron_threshold_eval
  import neuron_seq_pkg::*;
#(
  parameter int POTENTIAL_WIDTH = 9,
  parameter int THRESHOLD_WIDTH = 9,
  parameter int RW              = 1
) (
  input  logic signed [POTENTIAL_WIDTH-1:0] potential,
  input  logic signed [THRESHOLD_WIDTH-1:0] pos_threshold,
  input  logic signed [THRESHOLD_WIDTH-1:0] neg_threshold,
  input  logic signed [POTENTIAL_WIDTH-1:0] reset_potential,
  input  logic        [RW-1:0]              reset_mode,
  output logic signed [POTENTIAL_WIDTH-1:0] new_potential,
  output logic                              spike
);

  // Thresholds are sign-extended to the potential width so that compares and
  // subtractions happen at one width and wrap naturally on truncation.
  logic signed [POTENTIAL_WIDTH-1:0] pos_ext;
  logic signed [POTENTIAL_WIDTH-1:0] neg_ext;
  logic                              below;

  assign pos_ext = POTENTIAL_WIDTH'(pos_threshold);
  assign neg_ext = POTENTIAL_WIDTH'(neg_threshold);
  assign spike   = (potential >= pos_ext);
  assign below   = (potential <  neg_ext);

  always_comb begin
    new_potential = potential;
    if (spike) begin
      // Spike wins over the below-negative condition.
      if (reset_mode == RW'(RESET_HARD))        new_potential = reset_potential;
      else if (reset_mode == RW'(RESET_LINEAR)) new_potential = potential - pos_ext;
      else                                      new_potential = '0;
    end else if (below) begin
      if (reset_mode == RW'(RESET_HARD))        new_potential = -reset_potential;
      else if (reset_mode == RW'(RESET_LINEAR)) new_potential = potential - neg_ext;
      else                                      new_potential = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_tick_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : neuron_tick_sequencer                                            |
// | Purpose : Per-tick sweep over all neurons of a core. Each neuron is read,  |
// |           evaluated, written back, and a spike token is queued to the      |
// |           router when it fires. done pulses once the sweep has finished    |
// |           and the last token has been accepted.                            |
// | Ports   : clk, rst (async, active high)                                    |
// |           tick in / busy, done, tick_overrun out                           |
// |           mem_rd_en, mem_addr, mem_wr_en, mem_wr_data out                  |
// |           mem_potential, mem_pos_threshold, mem_neg_threshold,             |
// |           mem_reset_potential, mem_reset_mode in (1 cycle after rd_en)     |
// |           spike_valid, spike_neuron out / spike_ready in                   |
// |           spike_count out (only with NEURON_SEQ_SPIKE_COUNT_EN)            |
// | Config  : NEURON_SEQ_SPIKE_COUNT_EN adds the accepted-token counter.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module neuron_tick_sequencer
  import neuron_seq_pkg::*;
#(
  parameter  int NUM_NEURONS     = 256,
  parameter  int POTENTIAL_WIDTH = 9,
  parameter  int THRESHOLD_WIDTH = 9,
  parameter  int NUM_RESET_MODES = 2,
  localparam int NW              = $clog2(NUM_NEURONS),
  localparam int RW              = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  output logic                       busy,
  output logic                       done,
  output logic                       tick_overrun,
  output logic                       mem_rd_en,
  output logic [NW-1:0]              mem_addr,
  input  logic [POTENTIAL_WIDTH-1:0] mem_potential,
  input  logic [THRESHOLD_WIDTH-1:0] mem_pos_threshold,
  input  logic [THRESHOLD_WIDTH-1:0] mem_neg_threshold,
  input  logic [POTENTIAL_WIDTH-1:0] mem_reset_potential,
  input  logic [RW-1:0]              mem_reset_mode,
  output logic                       mem_wr_en,
  output logic [POTENTIAL_WIDTH-1:0] mem_wr_data,
  output logic                       spike_valid,
  output logic [NW-1:0]              spike_neuron,
  input  logic                       spike_ready
`ifdef NEURON_SEQ_SPIKE_COUNT_EN
  ,
  output logic [NW:0]                spike_count
`endif
);

  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NEURONS - 1);

  state_t                       state;
  state_t                       next_state;
  logic [NW-1:0]                idx;
  logic                         slot_free;
  logic                         is_last;
  logic                         eval_spike;
  logic [POTENTIAL_WIDTH-1:0]   eval_new;

  // A read may only start once the token register is empty or draining this
  // cycle; the following EVAL then always finds room for a new token.
  assign slot_free = !spike_valid || spike_ready;
  assign is_last   = (idx == LAST_IDX);

  neuron_threshold_eval #(
    .POTENTIAL_WIDTH (POTENTIAL_WIDTH),
    .THRESHOLD_WIDTH (THRESHOLD_WIDTH),
    .RW              (RW)
  ) u_eval (
    .potential       (mem_potential),
    .pos_threshold   (mem_pos_threshold),
    .neg_threshold   (mem_neg_threshold),
    .reset_potential (mem_reset_potential),
    .reset_mode      (mem_reset_mode),
    .new_potential   (eval_new),
    .spike           (eval_spike)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_addr    = idx;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick) next_state = READ;
      end
      READ: begin
        if (slot_free) begin
          mem_rd_en  = 1'b1;
          next_state = EVAL;
        end
      end
      EVAL: begin
        mem_wr_en   = 1'b1;
        mem_wr_data = eval_new;
        next_state  = is_last ? DONE : READ;
      end
      DONE: begin
        if (!spike_valid) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Index returns to 0 when leaving the last EVAL so it is already 0 in DONE
  // and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (state == EVAL) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid  <= 1'b0;
      spike_neuron <= '0;
    end else if (state == EVAL && eval_spike) begin
      spike_valid  <= 1'b1;
      spike_neuron <= idx;
    end else if (spike_valid && spike_ready) begin
      spike_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           tick_overrun <= 1'b0;
    else if (tick && state != IDLE)    tick_overrun <= 1'b1;
  end

`ifdef NEURON_SEQ_SPIKE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 spike_count <= '0;
    else if (state == IDLE && tick)          spike_count <= '0;
    else if (spike_valid && spike_ready)     spike_count <= spike_count + 1'b1;
  end
`endif

endmodule
`default_nettype wire
